// File: rtl/mem_access_unit_pkg.sv
// Shared codes and helpers for the load/store bus engine.
// Sizes, error codes, FSM states and lane byte-swap.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } mem_size_t;

    typedef mem_size_t size_t;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'd0,
        ERR_MISALIGNED = 2'd1,
        ERR_TIMEOUT    = 2'd2
    } mem_err_t;

    typedef logic [1:0] mem_state_t;

    localparam mem_state_t IDLE = 2'd0;
    localparam mem_state_t BUS  = 2'd1;
    localparam mem_state_t RESP = 2'd2;

    // Big-endian CPU word <-> little-lane Avalon word
    function automatic logic [31:0] swap_endian(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Combinational lane placement for stores and lane extraction
// plus sign/zero extension for loads.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_lane,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_data,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_lane,
    input  logic        ld_signed,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [4:0]  st_sh;
    logic [4:0]  ld_sh;
    logic [7:0]  b_lo;
    logic [7:0]  b_hi;
    logic [15:0] half;

    assign st_sh = {st_lane, 3'b000};
    assign ld_sh = {ld_lane, 3'b000};

    always_comb begin
        st_be   = 4'b0000;
        st_data = 32'h0;
        case (st_size)
            SIZE_BYTE: begin
                st_be   = 4'b0001 << st_lane;
                st_data = {24'h0, st_wdata[7:0]} << st_sh;
            end
            SIZE_HALF: begin
                st_be   = 4'b0011 << st_lane;
                st_data = {16'h0, st_wdata[7:0], st_wdata[15:8]} << st_sh;
            end
            SIZE_WORD: begin
                st_be   = 4'b1111;
                st_data = swap_endian(st_wdata);
            end
            default: ;
        endcase
    end

    // Half at lane L is {lane L, lane L+1}: lane L is the high byte
    assign b_lo = 8'(ld_rdata >> ld_sh);
    assign b_hi = 8'(ld_rdata >> (ld_sh + 5'd8));
    assign half = {b_lo, b_hi};

    always_comb begin
        ld_data = 32'h0;
        case (ld_size)
            SIZE_BYTE: ld_data = {{24{ld_signed & b_lo[7]}}, b_lo};
            SIZE_HALF: ld_data = {{16{ld_signed & half[15]}}, half};
            SIZE_WORD: ld_data = swap_endian(ld_rdata);
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store engine driving an Avalon-MM master
// port, with misalignment detection and an optional wait watchdog.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_signed_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic [1:0]  resp_err_o,
    output logic [31:0] address_o,
    output logic        read_o,
    output logic        write_o,
    input  logic        waitrequest_i,
    output logic [31:0] writedata_o,
    output logic [3:0]  byteenable_o,
    input  logic [31:0] readdata_i
);

    localparam bit          WDOG_EN = TIMEOUT_CYCLES != 0;
    localparam logic [31:0] WAIT_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

    mem_state_t  state;
    logic        lat_write;
    logic        lat_signed;
    logic [1:0]  lat_size;
    logic [1:0]  lat_lane;
    logic [31:0] wait_cnt;
    logic        misaligned;
    logic [3:0]  st_be;
    logic [31:0] st_data;
    logic [31:0] ld_data;

    assign misaligned =
        (req_size_i == SIZE_HALF && req_addr_i[0]) ||
        (req_size_i == SIZE_WORD && req_addr_i[1:0] != 2'b00);

    assign req_ready_o  = state == IDLE;
    assign resp_valid_o = state == RESP;
    assign read_o       = state == BUS && !lat_write;
    assign write_o      = state == BUS && lat_write;

    mem_lane_align u_align (
        .st_size   (req_size_i),
        .st_lane   (req_addr_i[1:0]),
        .st_wdata  (req_wdata_i),
        .st_be     (st_be),
        .st_data   (st_data),
        .ld_size   (lat_size),
        .ld_lane   (lat_lane),
        .ld_signed (lat_signed),
        .ld_rdata  (readdata_i),
        .ld_data   (ld_data)
    );

    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            state        <= IDLE;
            lat_write    <= 1'b0;
            lat_signed   <= 1'b0;
            lat_size     <= 2'd0;
            lat_lane     <= 2'd0;
            wait_cnt     <= 32'd0;
            resp_rdata_o <= 32'h0;
            resp_err_o   <= ERR_NONE;
            address_o    <= 32'h0;
            byteenable_o <= 4'h0;
            writedata_o  <= 32'h0;
        end else begin
            case (state)
                IDLE: if (req_valid_i) begin
                    lat_write  <= req_write_i;
                    lat_signed <= req_signed_i;
                    lat_size   <= req_size_i;
                    lat_lane   <= req_addr_i[1:0];
                    wait_cnt   <= 32'd0;
                    if (misaligned) begin
                        state        <= RESP;
                        resp_err_o   <= ERR_MISALIGNED;
                        resp_rdata_o <= 32'h0;
                    end else begin
                        state        <= BUS;
                        address_o    <= {req_addr_i[31:2], 2'b00};
                        byteenable_o <= st_be;
                        writedata_o  <= st_data;
                    end
                end
                BUS: begin
                    if (!waitrequest_i) begin
                        state        <= RESP;
                        resp_err_o   <= ERR_NONE;
                        resp_rdata_o <= lat_write ? 32'h0 : ld_data;
                    end else if (WDOG_EN && wait_cnt == WAIT_LAST) begin
                        state        <= RESP;
                        resp_err_o   <= ERR_TIMEOUT;
                        resp_rdata_o <= 32'h0;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store bus engine that sits directly downstream of the CPU datapath and drives the Avalon-MM master port on its behalf.
- Accepts one request at a time, carrying address, size, signedness, direction and store data.
- Generates word-aligned address, byteenable and lane-placed writedata, and honours waitrequest.
- Returns sign/zero-extended, big-endian-correct load data with a single-cycle response pulse, which replaces the datapath's fixed byteenable=1111 and stall=0.

Parameters:
- TIMEOUT_CYCLES, 0, max waitrequest-high cycles before abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- reset_n_i  in  1  synchronous active-low reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  unit can accept a request this cycle.
- req_write_i  in  1  1=store, 0=load.
- req_size_i  in  2  mem_size_t: SIZE_BYTE, SIZE_HALF, SIZE_WORD.
- req_signed_i  in  1  sign-extend load (LB/LH); ignored for word and for stores.
- req_addr_i  in  32  byte address.
- req_wdata_i  in  32  store value, right-justified (byte in [7:0], half in [15:0]).
- resp_valid_o  out  1  one-cycle completion pulse.
- resp_rdata_o  out  32  extended load result; 0 for stores and errors.
- resp_err_o  out  2  mem_err_t: ERR_NONE, ERR_MISALIGNED, ERR_TIMEOUT.
- address_o  out  32  Avalon address, always {addr[31:2],2'b00}.
- read_o  out  1  Avalon read.
- write_o  out  1  Avalon write.
- waitrequest_i  in  1  Avalon waitrequest.
- writedata_o  out  32  Avalon writedata.
- byteenable_o  out  4  Avalon byteenable.
- readdata_i  in  32  Avalon readdata, valid in the cycle read_o=1 and waitrequest_i=0.

Behaviour:
- Byte lanes: byte at address A is in lane L=A[1:0], bits [8L+7:8L]. MIPS is big-endian.
  - Half at A = {lane L, lane L+1}.
  - Word = {lane0, lane1, lane2, lane3}.
- FSM states (mem_state_t): IDLE, BUS, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, latch all request fields.
  - Misaligned request (half with A[0]=1, or word with A[1:0]!=0): go to RESP with ERR_MISALIGNED; read_o and write_o are never asserted.
  - Otherwise go to BUS.
- BUS:
  - read_o=!req_write or write_o=req_write, address_o/byteenable_o/writedata_o are driven from registered values and held stable.
  - req_ready_o=0.
  - When waitrequest_i=0: capture readdata_i (loads), go to RESP. read_o/write_o drop at the next edge.
- Watchdog: a wait counter clears on entry to BUS and increments each BUS cycle with waitrequest_i=1. If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES, go to RESP with ERR_TIMEOUT and resp_rdata_o=0.
- RESP: resp_valid_o=1 for exactly one cycle, then IDLE. req_ready_o=0.
- Latency: accept at edge t, BUS during t+1. With zero waits resp_valid_o is high during t+2. Each wait cycle adds 1.
- byteenable_o:
  - byte: 4'b0001<<L.
  - half: 4'b0011<<L.
  - word: 4'b1111.
- writedata_o:
  - byte: wdata[7:0] in lane L.
  - half: wdata[15:8] in lane L, wdata[7:0] in lane L+1.
  - word: byte-swap of wdata.
  - Unused lanes are 0.
- Loads: select lanes per size.
  - Sign-extend from bit 7/15 when req_signed, else zero-extend.
  - Word is byte-swapped readdata_i.
- Outside BUS: read_o=write_o=0; address_o, byteenable_o and writedata_o hold their last values.
- A req_valid_i arriving while not in IDLE is ignored (ready=0). The requester holds it until ready.
- Reset (reset_n_i=0 at an edge), from any state:
  - state=IDLE; read_o=write_o=0, resp_valid_o=0, resp_err_o=ERR_NONE.
  - resp_rdata_o=0, address_o=0, byteenable_o=0, writedata_o=0, wait counter=0.
  - An in-flight transfer is abandoned with no response.
  - req_ready_o is 1 from the first cycle after reset release.

Decomposition:
- Add to package codes:
  - mem_size_t (SIZE_BYTE=0, SIZE_HALF=1, SIZE_WORD=2).
  - mem_err_t (ERR_NONE=0, ERR_MISALIGNED=1, ERR_TIMEOUT=2).
  - mem_state_t (IDLE, BUS, RESP).
  - Reuse size_t and swap_endian, moving swap_endian into the package.
- One sub-module, mem_lane_align: purely combinational.
  - Store side: size + lane + wdata -> byteenable, writedata.
  - Load side: size + lane + signed + readdata -> extended result.
- The FSM, latches and watchdog stay in mem_access_unit.

Test Plan:
- Word load, A=0x1000, readdata_i=0x78563412, waitrequest high 2 cycles -> read_o high 3 cycles, address_o=0x1000, byteenable_o=1111, resp_rdata_o=0x12345678 and resp_valid_o 5 cycles after accept.
- LB signed, A=0x2003, readdata_i=0x80000000, no wait -> byteenable_o=1000, resp_rdata_o=0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH, A=0x1002, wdata=0x0000BEEF -> write_o=1, address_o=0x1000, byteenable_o=1100, writedata_o=0xEFBE0000, resp_rdata_o=0.
- LH, A=0x1001 -> resp_err_o=ERR_MISALIGNED, read_o never asserted, resp_valid_o 2 cycles after accept.
- TIMEOUT_CYCLES=4, waitrequest_i stuck high on a load -> read_o drops after 4 wait cycles, resp_err_o=ERR_TIMEOUT, resp_rdata_o=0.
- reset_n_i low during BUS with waitrequest high -> next cycle read_o=0, no resp_valid_o, req_ready_o=1 after release.
